// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared states, default widths and counter sizing for mem_bus_ctrl
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, TURN, READ} state_t;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/mem_bus_wait_cnt.sv
// mem_bus_wait_cnt: loadable down-counter; expired marks the final counted cycle
module mem_bus_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - W'(1) : '0);
  assign expired = cnt == W'(1);
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-request load/store controller to main-memory pins with read waits and write turnaround.
// Define MEM_BUS_WRITE_ACK_EN to also acknowledge stores with an rsp_valid pulse (rsp_rdata = 0).
module mem_bus_ctrl import mem_bus_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din
);
  localparam int CW = cnt_width(WAIT_CYCLES, TURN_CYCLES);
  if (WAIT_CYCLES < 1 || TURN_CYCLES < 1) begin : g_bad_param
    $error("mem_bus_ctrl: WAIT_CYCLES and TURN_CYCLES must be >= 1");
  end
  state_t state;
  logic expired, cnt_load;
  logic [CW-1:0] cnt_val;
  assign req_ready = state == IDLE;
  // READ counts from the accept edge, TURN from the edge leaving WRITE
  assign cnt_load = (req_ready && req_valid && !req_we) || state == WRITE;
  assign cnt_val = state == WRITE ? CW'(TURN_CYCLES) : CW'(WAIT_CYCLES);
  mem_bus_wait_cnt #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val(cnt_val), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_dout <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          bus_addr <= req_addr;
          if (req_we) begin
            bus_dout <= req_wdata;
            bus_we <= 1'b1;
            state <= WRITE;
          end else state <= READ;
        end
        WRITE: begin
          bus_we <= 1'b0;
          state <= TURN;
`ifdef MEM_BUS_WRITE_ACK_EN
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
`endif
        end
        TURN: if (expired) state <= IDLE;
        READ: if (expired) begin
          rsp_rdata <= bus_din;
          rsp_valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of mem_bus_ctrl at default parameters (WAIT_CYCLES=2, TURN_CYCLES=1)
module tb_mem_bus_ctrl;
`ifdef MEM_BUS_WRITE_ACK_EN
  localparam logic ACK = 1'b1;
`else
  localparam logic ACK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_ready, rsp_valid, bus_we;
  logic [7:0] req_addr = '0, bus_addr;
  logic [15:0] req_wdata = '0, rsp_rdata, bus_dout, bus_din = '0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_dout(bus_dout), .bus_din(bus_din)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic we, input logic [7:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
  endtask
  initial begin
    tick;
    tick;
    check("rst_ready", req_ready, 1);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_dout", bus_dout, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    tick;
    // single store
    req(1'b1, 8'h3C, 16'hBEEF);
    tick;
    req_valid = 1'b0;
    req_addr = 8'h55;
    req_wdata = 16'h0000;
    check("st_we_e0", bus_we, 1);
    check("st_addr", bus_addr, 8'h3C);
    check("st_dout", bus_dout, 16'hBEEF);
    check("st_ready_e0", req_ready, 0);
    tick;
    check("st_we_e1", bus_we, 0);
    check("st_ready_e1", req_ready, 0);
    check("st_ack_e1", rsp_valid, ACK);
    tick;
    check("st_ready_e2", req_ready, 1);
    check("st_rsp_e2", rsp_valid, 0);
    check("st_addr_hold", bus_addr, 8'h3C);
    // single load
    req(1'b0, 8'h10, 16'h0);
    tick;
    req_valid = 1'b0;
    check("ld_addr", bus_addr, 8'h10);
    check("ld_we_e0", bus_we, 0);
    check("ld_ready_e0", req_ready, 0);
    bus_din = 16'h1234;
    tick;
    check("ld_rsp_e1", rsp_valid, 0);
    check("ld_we_e1", bus_we, 0);
    tick;
    bus_din = 16'hFFFF;
    check("ld_rsp_e2", rsp_valid, 1);
    check("ld_rdata", rsp_rdata, 16'h1234);
    check("ld_ready_e2", req_ready, 1);
    tick;
    check("ld_rsp_e3", rsp_valid, 0);
    check("ld_rdata_hold", rsp_rdata, 16'h1234);
    // store then load held on req_valid with changing fields
    req(1'b1, 8'h20, 16'hAAAA);
    tick;
    req(1'b0, 8'h21, 16'h1111);
    check("sl_we_e0", bus_we, 1);
    check("sl_dout", bus_dout, 16'hAAAA);
    tick;
    req_addr = 8'h22;
    req_wdata = 16'h2222;
    check("sl_addr_e1", bus_addr, 8'h20);
    check("sl_we_e1", bus_we, 0);
    check("sl_ready_e1", req_ready, 0);
    tick;
    check("sl_addr_e2", bus_addr, 8'h20);
    check("sl_ready_e2", req_ready, 1);
    tick;
    req_valid = 1'b0;
    bus_din = 16'h5A5A;
    check("sl_ld_addr", bus_addr, 8'h22);
    check("sl_ld_we", bus_we, 0);
    check("sl_dout_hold", bus_dout, 16'hAAAA);
    tick;
    check("sl_we_read", bus_we, 0);
    check("sl_rsp_e1", rsp_valid, 0);
    tick;
    check("sl_rsp", rsp_valid, 1);
    check("sl_rdata", rsp_rdata, 16'h5A5A);
    // back-to-back loads with req_valid held
    req(1'b0, 8'h40, 16'h0);
    bus_din = 16'h1111;
    tick;
    req_addr = 8'h41;
    check("bb_addr0", bus_addr, 8'h40);
    check("bb_rsp_prev_clear", rsp_valid, 0);
    tick;
    tick;
    bus_din = 16'h2222;
    check("bb_rsp0", rsp_valid, 1);
    check("bb_rdata0", rsp_rdata, 16'h1111);
    check("bb_ready_with_rsp", req_ready, 1);
    tick;
    req_valid = 1'b0;
    check("bb_addr1", bus_addr, 8'h41);
    check("bb_rsp_a3", rsp_valid, 0);
    tick;
    tick;
    check("bb_rsp1", rsp_valid, 1);
    check("bb_rdata1", rsp_rdata, 16'h2222);
    // store 0x0001: acknowledged only with MEM_BUS_WRITE_ACK_EN
    tick;
    req(1'b1, 8'h01, 16'h0001);
    tick;
    req_valid = 1'b0;
    check("ack_we", bus_we, 1);
    tick;
    check("ack_valid", rsp_valid, ACK);
    check("ack_rdata", rsp_rdata, ACK ? 16'h0000 : 16'h2222);
    tick;
    check("ack_clear", rsp_valid, 0);
    // reset in the middle of a write
    req(1'b1, 8'h77, 16'h1357);
    tick;
    req_valid = 1'b0;
    check("mr_we_before", bus_we, 1);
    #1 rst = 1'b1;
    #1;
    check("mr_we_async", bus_we, 0);
    check("mr_ready_async", req_ready, 1);
    check("mr_addr_async", bus_addr, 0);
    rst = 1'b0;
    tick;
    check("mr_ready", req_ready, 1);
    check("mr_rsp0", rsp_valid, 0);
    tick;
    check("mr_rsp1", rsp_valid, 0);
    check("mr_we", bus_we, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
